if_prefetch_unit: RTL and testbench
===================================

Name: if_prefetch_unit

Overview:
Parametrised instruction-fetch stage with a prefetch queue.
- Drives a synchronous-read instruction memory (1-cycle read latency).
- Buffers up to DEPTH fetched {pc, instr} pairs and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing queued and in-flight fetches.
- Replaces the single-register PC + flush-mux fetch stage. The IFWrite-style stall is replaced by back-pressure (out_ready).

Parameters:
XLEN, 32, PC and instruction width
IMEM_AW, 6, instruction memory word-address width (imem holds 2^IMEM_AW words)
DEPTH, 4, prefetch queue entries; legal range 2..16
RESET_PC, 32'h0000_0000, PC fetched first after reset (word aligned)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  XLEN  target PC; bits [1:0] ignored
imem_req  out  1  read strobe to instruction memory
imem_addr  out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]
imem_rdata  in  XLEN  read data, valid the cycle after imem_req
out_valid  out  1  queue head holds a valid instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  XLEN  head instruction
out_pc  out  XLEN  head PC
flush_o  out  1  = redirect_valid (combinational), tells decode to kill its stage

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release):
  - fetch_pc = RESET_PC; queue empty; in-flight flag = 0.
  - out_valid = 0, imem_req = 0, out_instr = 0, out_pc = 0.
  - Reset asserted mid-operation discards everything immediately.
- Credit rule: imem_req = !redirect_valid && (count + inflight - pop) < DEPTH.
  - pop = out_valid & out_ready; inflight = request issued the previous cycle and not killed.
  - The queue therefore never overflows, and no push is ever dropped for lack of space.
- Request issue: on an imem_req cycle, record inflight_pc = fetch_pc and advance fetch_pc += 4. The PC wraps modulo 2^XLEN. imem_addr wraps modulo 2^IMEM_AW.
- Response: the cycle after an issued request, push {inflight_pc, imem_rdata} into the queue tail, unless killed.
- Queue behaviour:
  - Push and pop in the same cycle is legal at any occupancy.
  - Head outputs are registered, with no bypass. A fetched instruction is visible at out_valid 2 cycles after its imem_req.
- Throughput: with out_ready held high, steady state is 1 instruction/cycle for any DEPTH >= 2.
- Redirect (redirect_valid=1 at a clock edge):
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Queue is cleared (count=0) and any in-flight response is killed, i.e. not pushed next cycle.
  - imem_req = 0 that cycle. Fetch resumes at the target the following cycle, with first out_valid 2 cycles after that.
- Simultaneous redirect and pop: the pop handshake still completes (decode owns that instruction and uses flush_o to kill it); redirect wins for all internal state.
- Back-to-back redirects: the last one wins. No request is issued while redirect_valid is held.
- out_instr/out_pc hold stable while out_valid=1 and out_ready=0.
- Empty queue: out_valid=0, and out_instr/out_pc hold their last values (don't-care).

Decomposition:
- Shared package (riscv_pkg): XLEN, NOP encoding (32'h0000_0013), fetch entry struct {pc, instr}.
- Sub-module if_fifo: DEPTH x (2*XLEN) synchronous FIFO with push, pop, clear, count, head outputs and an asynchronous active-low reset. It is instantiated once.
- Top level holds fetch_pc, the in-flight/kill flag and the credit logic.

Test Plan:
- Reset release, out_ready=1, imem word k = 32'h1000_0000+k -> imem_req first high cycle 0 addr 0; out_valid cycle 2 with pc 0/instr 32'h1000_0000; then pc 4, 8, ... one per cycle.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 entries queued, imem_req low once credits are exhausted; release -> pcs 0,4,8,12,16 in order, with no gaps or duplicates.
- redirect_valid with redirect_pc=32'h40 while queue holds 3 entries and a request is in flight -> out_valid=0 next cycle; first delivered pc=0x40 two cycles after fetch resumes; no stale pc ever delivered.
- redirect_pc=32'h43 -> fetch starts at 0x40, imem_addr=16.
- IMEM_AW=6, fetch past pc 0xFC -> imem_addr wraps 63->0 while out_pc continues 0x100.
- reset_n pulsed low mid-stream (asynchronously, between edges) -> out_valid and imem_req drop immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Types and constants shared by the instruction-fetch slice.
// Holds the fetch entry layout and the pointer-wrap helper for the prefetch queue.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Ring-pointer increment for queues whose depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
    return (idx + 1 >= depth) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch queue: DEPTH entries, same-cycle push/pop at any occupancy,
// synchronous clear, and a registered head with no push-to-head bypass.
module if_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 2 * XLEN,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output logic [W-1:0]  head_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] wr_next;
  logic [CW-1:0] occ_after_pop;

  assign rd_next       = PW'(wrap_inc(32'(rd_ptr), DEPTH));
  assign wr_next       = PW'(wrap_inc(32'(wr_ptr), DEPTH));
  assign occ_after_pop = count - CW'(pop);
  assign head_valid    = (count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_next;
      if (pop)  rd_ptr <= rd_next;
      count <= occ_after_pop + CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  // The head register refills from the new tail only when the queue would
  // otherwise be empty; otherwise it advances to the already-stored next entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data <= '0;
    end else if (!clear) begin
      if (occ_after_pop == '0) begin
        if (push) head_data <= push_data;
      end else if (pop) begin
        head_data <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: issues word reads to a 1-cycle synchronous imem and
// buffers {pc, instr} pairs for decode, flushing everything on a redirect.
module if_prefetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              IMEM_AW  = 6,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic               flush_o
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   inflight_pc;
  logic              inflight;
  logic              pop;
  logic              push;
  logic [CW-1:0]     count;
  logic [CW1-1:0]    credit_used;
  logic [2*XLEN-1:0] head_data;
  logic              unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign flush_o   = redirect_valid;
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~redirect_valid;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  // Slots already spoken for once this cycle's pop retires: a new request is
  // only issued if its response is guaranteed a queue slot.
  assign credit_used = {1'b0, count} + CW1'(inflight) - CW1'(pop);
  assign imem_req    = reset_n & ~redirect_valid & (credit_used < CW1'(DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
    end
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * XLEN)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  ({inflight_pc, imem_rdata}),
    .pop        (pop),
    .clear      (redirect_valid),
    .count      (count),
    .head_valid (out_valid),
    .head_data  (head_data)
  );

  assign out_pc    = head_data[2*XLEN-1:XLEN];
  assign out_instr = head_data[XLEN-1:0];

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed latency/credit/redirect/reset scenarios
// plus a randomized run checked against an in-order fetch-stream model.
module tb_if_prefetch_unit;
  import riscv_pkg::*;

  localparam int IMEM_AW = 6;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [31:0]        redirect_pc = '0;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [31:0]        out_instr;
  logic [31:0]        out_pc;
  logic               flush_o;

  logic [31:0] mem [64];
  int n_cmp = 0;
  int n_err = 0;

  if_prefetch_unit #(
    .XLEN     (32),
    .IMEM_AW  (IMEM_AW),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .flush_o        (flush_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_linear();
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
  endtask

  // Leaves the bench just after a clock edge with reset released: cycle 0.
  task automatic apply_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++;
    if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_cmp++;
    if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    $display("reset: outputs checked");
  endtask

  task automatic test_startup();
    logic [31:0] exp_req;
    logic [31:0] exp_out;
    exp_req = 32'h0;
    exp_out = 32'h0;
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp_req[IMEM_AW+1:2]) begin
        n_err++;
        $display("FAIL startup_req c%0d: got req=%b addr=%0d want req=1 addr=%0d",
                 c, imem_req, imem_addr, exp_req[IMEM_AW+1:2]);
      end
      exp_req += 4;
      n_cmp++;
      if (c < 2) begin
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL startup_early c%0d: got valid=%b want 0", c, out_valid); end
      end else begin
        if (out_valid !== 1'b1 || out_pc !== exp_out || out_instr !== mem[exp_out[IMEM_AW+1:2]]) begin
          n_err++;
          $display("FAIL startup_out c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                   c, out_valid, out_pc, out_instr, exp_out, mem[exp_out[IMEM_AW+1:2]]);
        end else begin
          $display("startup: pc=%h instr=%h", out_pc, out_instr);
        end
        exp_out += 4;
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    int reqs;
    reqs = 0;
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req) reqs++;
      if (c == 9) begin
        n_cmp++;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b want 0", imem_req); end
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
          n_err++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (reqs != DEPTH) begin n_err++; $display("FAIL stall_credits: got %0d requests want %0d", reqs, DEPTH); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== mem[i]) begin
        n_err++;
        $display("FAIL stall_drain %0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, 32'(4 * i), mem[i]);
      end else begin
        $display("stall drain: pc=%h instr=%h", out_pc, out_instr);
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect(input logic [31:0] target);
    logic [31:0] aligned;
    aligned = {target[31:2], 2'b00};
    apply_reset();
    out_ready = 1'b0;
    repeat (4) next_cycle();
    // Three entries queued and one response in flight at this point.
    redirect_valid = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || flush_o !== 1'b1) begin
      n_err++; $display("FAIL redir_cycle: got req=%b flush=%b want req=0 flush=1", imem_req, flush_o);
    end
    next_cycle();
    redirect_valid = 1'b0;
    redirect_pc = $urandom;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== aligned[IMEM_AW+1:2]) begin
      n_err++;
      $display("FAIL redir_resume: got v=%b req=%b addr=%0d want v=0 req=1 addr=%0d",
               out_valid, imem_req, imem_addr, aligned[IMEM_AW+1:2]);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_gap: got v=%b want 0", out_valid); end
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== aligned + 32'(4 * i) ||
          out_instr !== mem[(aligned[IMEM_AW+1:2] + IMEM_AW'(i))]) begin
        n_err++;
        $display("FAIL redir_stream %0d: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, aligned + 32'(4 * i));
      end else begin
        $display("redirect %h: pc=%h instr=%h", target, out_pc, out_instr);
      end
      out_ready = 1'b1;
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b1;
    repeat (6) next_cycle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got v=%b want 1", out_valid); end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_err++;
      $display("FAIL areset_drop: got v=%b req=%b pc=%h instr=%h want all 0", out_valid, imem_req, out_pc, out_instr);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== '0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL areset_restart: got req=%b addr=%0d v=%b want req=1 addr=0 v=0", imem_req, imem_addr, out_valid);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem[0]) begin
      n_err++; $display("FAIL areset_first: got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h", out_valid, out_pc, out_instr, mem[0]);
    end
    $display("async reset: restart checked");
  endtask

  task automatic test_random();
    fetch_entry_t exp;
    logic [31:0]  exp_pc;
    int           reqs;
    int           pops;
    logic         prev_hold;
    logic [31:0]  prev_pc;
    logic [31:0]  prev_instr;
    logic         done;
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    exp_pc = 32'h0;
    reqs = 0;
    pops = 0;
    prev_hold = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      @(negedge clk);
      n_cmp++;
      if (flush_o !== redirect_valid) begin n_err++; $display("FAIL rnd_flush c%0d: got %b want %b", c, flush_o, redirect_valid); end
      if (redirect_valid) begin
        n_cmp++;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL rnd_redir_req c%0d: got %b want 0", c, imem_req); end
      end
      if (prev_hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
          n_err++;
          $display("FAIL rnd_hold c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                   c, out_valid, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      if (imem_req) reqs++;
      if (out_valid && out_ready) begin
        exp.pc = exp_pc;
        exp.instr = mem[exp_pc[IMEM_AW+1:2]];
        n_cmp++;
        if ({out_pc, out_instr} !== exp) begin
          n_err++;
          $display("FAIL rnd_data c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, out_pc, out_instr, exp.pc, exp.instr);
        end else begin
          $display("txn c%0d: pc=%h instr=%h", c, out_pc, out_instr);
        end
        exp_pc += 4;
        pops++;
      end
      n_cmp++;
      if (reqs - pops > DEPTH) begin n_err++; $display("FAIL rnd_credit c%0d: got %0d outstanding want <= %0d", c, reqs - pops, DEPTH); end
      prev_hold = out_valid && !out_ready && !redirect_valid;
      prev_pc = out_pc;
      prev_instr = out_instr;
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
        reqs = 0;
        pops = 0;
      end
      next_cycle();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (out_valid) begin
        done = 1'b1;
        n_cmp++;
        if (out_pc !== exp_pc || out_instr !== mem[exp_pc[IMEM_AW+1:2]]) begin
          n_err++; $display("FAIL rnd_drain: got pc=%h instr=%h want pc=%h", out_pc, out_instr, exp_pc);
        end
      end
      next_cycle();
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL rnd_drain_timeout: got no out_valid in 10 cycles want valid");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_linear();
    test_reset();
    test_startup();
    test_stall();
    test_redirect(32'h0000_0040);
    test_redirect(32'h0000_0043);
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
